// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC unit: PC/branch/jump/vector selection with supervisor bit,
// IRQ masking and exception-PC capture. Return-address stack built only with PC_RAS_EN.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    RAS_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] ILLOP_VECTOR = 32'h8000_0004,
  parameter logic [ADDR_WIDTH-1:0] XADDR_VECTOR = 32'h8000_0008
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  STALL,
  input  logic [2:0]            PCSEL,
  input  logic                  IRQ,
  input  logic                  CALL,
  input  logic [ADDR_WIDTH-1:0] JT,
  input  logic [ADDR_WIDTH-1:0] ShftSextC,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] PcIncr,
  output logic [ADDR_WIDTH-1:0] branchOffset,
  output logic [ADDR_WIDTH-1:0] xp_o,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_underflow
);
  localparam int              MSB   = ADDR_WIDTH - 1;
  localparam logic [MSB:0]    ALIGN = ~ADDR_WIDTH'(3);

  logic         s, irq_take, ret_ok, xp_cap;
  logic [MSB:0] ret_pc, pc_n;

  assign s            = pc_o[MSB];
  assign irq_take     = IRQ & ~s;
  assign PcIncr       = pc_o + ADDR_WIDTH'(4);
  assign branchOffset = PcIncr + ShftSextC;

  // Relative targets keep S; only jumps and returns may clear it.
  always_comb begin
    pc_n   = pc_o;
    xp_cap = 1'b0;
    if (irq_take) begin
      pc_n   = XADDR_VECTOR;
      xp_cap = 1'b1;
    end else begin
      case (PCSEL)
        3'b000: pc_n = {s, PcIncr[MSB-1:0]};
        3'b001: pc_n = {s, branchOffset[MSB-1:0]};
        3'b010: pc_n = {s & JT[MSB], JT[MSB-1:0]};
        3'b011: begin pc_n = ILLOP_VECTOR; xp_cap = 1'b1; end
        3'b100: begin pc_n = XADDR_VECTOR; xp_cap = 1'b1; end
        3'b101: begin
          if (ret_ok) begin
            pc_n = {s & ret_pc[MSB], ret_pc[MSB-1:0]};
          end else begin
            pc_n   = ILLOP_VECTOR;
            xp_cap = 1'b1;
          end
        end
        default: pc_n = RESET_VECTOR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      pc_o <= RESET_VECTOR & ALIGN;
      xp_o <= '0;
    end else if (!STALL) begin
      pc_o <= pc_n & ALIGN;
      if (xp_cap) xp_o <= PcIncr;
    end
  end

`ifdef PC_RAS_EN
  localparam int           PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0]  FULL = (PW+1)'(RAS_DEPTH);

  logic [MSB:0]  ras [RAS_DEPTH];
  logic [PW-1:0] sp, sp_top;
  logic [PW:0]   cnt, cnt_n;
  logic          active, is_ret, pop, push;

  // Circular buffer: sp is the next write slot, so when full it points at the oldest entry.
  assign sp_top = sp - PW'(1);
  assign ret_ok = (cnt != '0);
  assign ret_pc = ras[sp_top];
  assign active = ~STALL & ~irq_take;
  assign is_ret = active & (PCSEL == 3'b101);
  assign pop    = is_ret & ret_ok;
  assign push   = active & CALL & ((PCSEL == 3'b001) | (PCSEL == 3'b010) | pop);

  always_comb begin
    cnt_n = cnt;
    if (push && !pop && cnt != FULL) cnt_n = cnt + (PW+1)'(1);
    else if (pop && !push)           cnt_n = cnt - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !RESET) ras[pop ? sp_top : sp] <= PcIncr;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sp            <= '0;
      cnt           <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= is_ret & ~ret_ok;
      cnt           <= cnt_n;
      ras_empty     <= (cnt_n == '0);
      ras_full      <= (cnt_n == FULL);
      if (push && !pop)      sp <= sp + PW'(1);
      else if (pop && !push) sp <= sp_top;
    end
  end
`else
  logic unused_cfg;
  assign ret_ok        = 1'b0;
  assign ret_pc        = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
  assign unused_cfg    = CALL ^ (RAS_DEPTH > 1);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based next-PC model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_pc_sequencer;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] ILL_V = 32'h8000_0004;
  localparam logic [31:0] X_V   = 32'h8000_0008;

  logic        clk = 1'b0, RESET = 1'b1, STALL = 1'b0, IRQ = 1'b0, CALL = 1'b0;
  logic [2:0]  PCSEL = 3'b000;
  logic [31:0] JT = '0, C = '0;
  logic [31:0] pc_o, PcIncr, branchOffset, xp_o;
  logic        ras_empty, ras_full, ras_underflow;

  pc_sequencer dut (
    .clk(clk), .RESET(RESET), .STALL(STALL), .PCSEL(PCSEL), .IRQ(IRQ), .CALL(CALL),
    .JT(JT), .ShftSextC(C), .pc_o(pc_o), .PcIncr(PcIncr), .branchOffset(branchOffset),
    .xp_o(xp_o), .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_pc, m_xp;
  bit          m_uf;
  logic [31:0] m_ras[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_V;
    m_xp = '0;
    m_uf = 1'b0;
    m_ras.delete();
  endtask

  // Next state from the selection rules; the return stack is a bounded LIFO queue.
  task automatic model_step();
    logic [31:0] incr, npc, t;
    logic        s;
    incr = m_pc + 32'd4;
    s    = m_pc[31];
    m_uf = 1'b0;
    if (STALL) return;
    npc = m_pc;
    if (IRQ && !s) begin
      npc  = X_V;
      m_xp = incr;
    end else begin
      case (PCSEL)
        3'd0: npc = {s, incr[30:0]};
        3'd1: begin t = incr + C; npc = {s, t[30:0]}; end
        3'd2: npc = {s & JT[31], JT[30:0]};
        3'd3: begin npc = ILL_V; m_xp = incr; end
        3'd4: begin npc = X_V; m_xp = incr; end
        3'd5: begin
          if (RAS_EN && m_ras.size() > 0) begin
            t   = m_ras.pop_back();
            npc = {s & t[31], t[30:0]};
            if (CALL) m_ras.push_back(incr);
          end else begin
            npc  = ILL_V;
            m_xp = incr;
            m_uf = RAS_EN;
          end
        end
        default: npc = RST_V;
      endcase
      if (RAS_EN && CALL && (PCSEL == 3'd1 || PCSEL == 3'd2)) begin
        m_ras.push_back(incr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
    m_pc = {npc[31:2], 2'b00};
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_o",          pc_o,                 m_pc);
      chk("PcIncr",        PcIncr,               m_pc + 32'd4);
      chk("branchOffset",  branchOffset,         m_pc + 32'd4 + C);
      chk("xp_o",          xp_o,                 m_xp);
      chk("ras_empty",     32'(ras_empty),       32'(m_ras.size() == 0));
      chk("ras_full",      32'(ras_full),        32'(m_ras.size() == 4));
      chk("ras_underflow", 32'(ras_underflow),   32'(m_uf));
    end
  end

  task automatic step(input logic [2:0] sel, input logic [31:0] jt, input logic [31:0] c,
                      input bit call, input bit irq, input bit stall);
    @(negedge clk);
    #2;
    PCSEL = sel; JT = jt; C = c; CALL = call; IRQ = irq; STALL = stall;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc",    pc_o,                RST_V);
    chk("rst_xp",    xp_o,                32'h0);
    chk("rst_empty", 32'(ras_empty),      32'd1);
    chk("rst_full",  32'(ras_full),       32'd0);
    chk("rst_uf",    32'(ras_underflow),  32'd0);
    #1 RESET = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    chk("inc1", pc_o, 32'h8000_0004);
    step(3'b000, 0, 0, 0, 0, 0);
    chk("inc2", pc_o, 32'h8000_0008);
    step(3'b000, 0, 0, 0, 0, 0);
    chk("inc3", pc_o, 32'h8000_000C);
    chk("inc3_pcincr", PcIncr, 32'h8000_0010);

    // jumps never enter supervisor mode
    step(3'b010, 32'h0000_0100, 0, 0, 0, 0);
    chk("jmp_leave", pc_o, 32'h0000_0100);
    step(3'b010, 32'h8000_0203, 0, 0, 0, 0);
    chk("jmp_user", pc_o, 32'h0000_0200);
    step(3'b110, 0, 0, 0, 0, 0);
    chk("sel110", pc_o, RST_V);
    step(3'b001, 0, 32'h0000_00FC, 0, 0, 0);
    chk("br_sup", pc_o, 32'h8000_0100);
    step(3'b010, 32'h8000_0203, 0, 0, 0, 0);
    chk("jmp_sup", pc_o, 32'h8000_0200);

    // call then return
    step(3'b010, 32'h0000_0010, 0, 0, 0, 0);
    step(3'b001, 0, 32'h0000_0040, 1, 0, 0);
    chk("call_pc", pc_o, 32'h0000_0054);
    chk("call_empty", 32'(ras_empty), 32'(!RAS_EN));
    step(3'b101, 0, 0, 0, 0, 0);
    chk("ret_pc", pc_o, RAS_EN ? 32'h0000_0014 : ILL_V);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // overfill then drain past empty
    step(3'b010, 32'h0000_1000, 0, 0, 0, 0);
    for (int k = 2; k <= 6; k++) step(3'b010, 32'(k) << 12, 0, 1, 0, 0);
    chk("full", 32'(ras_full), 32'(RAS_EN));
    step(3'b101, 0, 0, 0, 0, 0);
    chk("ret_a5", pc_o, RAS_EN ? 32'h0000_5004 : ILL_V);
    for (int k = 0; k < 4; k++) step(3'b101, 0, 0, 0, 0, 0);
    chk("uf_pc", pc_o, ILL_V);
    chk("uf_xp", xp_o, RAS_EN ? 32'h0000_2008 : 32'h8000_0008);
    chk("uf_pulse", 32'(ras_underflow), 32'(RAS_EN));
    step(3'b000, 0, 0, 0, 0, 0);
    chk("uf_drop", 32'(ras_underflow), 32'd0);

    // IRQ accepted in user mode, masked in supervisor
    step(3'b010, 32'h0000_0020, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 1, 0);
    chk("irq_pc", pc_o, X_V);
    chk("irq_xp", xp_o, 32'h0000_0024);
    step(3'b000, 0, 0, 0, 1, 0);
    chk("irq_masked", pc_o, 32'h8000_000C);

    // vectors and modulo wrap that must not disturb S
    step(3'b011, 0, 0, 0, 0, 0);
    chk("illop_xp", xp_o, 32'h8000_0010);
    step(3'b100, 0, 0, 0, 0, 0);
    step(3'b111, 0, 0, 0, 0, 0);
    chk("sel111", pc_o, RST_V);
    step(3'b001, 0, 32'h7FFF_FFF8, 0, 0, 0);
    chk("br_top", pc_o, 32'hFFFF_FFFC);
    step(3'b000, 0, 0, 0, 0, 0);
    chk("wrap_sup", pc_o, 32'h8000_0000);
    step(3'b010, 32'h7FFF_FFFC, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0, 0);
    chk("wrap_user", pc_o, 32'h0000_0000);
    step(3'b001, 0, 32'hFFFF_FFF0, 0, 0, 0);
    chk("br_neg", pc_o, 32'h7FFF_FFF4);

    // stall holds everything, pending IRQ taken afterwards
    step(3'b010, 32'h0000_0040, 0, 0, 0, 0);
    step(3'b010, 32'h0000_0080, 0, 1, 0, 0);
    repeat (3) step(3'b001, 0, 32'h0000_0100, 1, 1, 1);
    chk("stall_pc", pc_o, 32'h0000_0080);
    chk("stall_empty", 32'(ras_empty), 32'(!RAS_EN));
    step(3'b000, 0, 0, 0, 1, 0);
    chk("post_stall_irq", pc_o, X_V);
    chk("post_stall_xp", xp_o, 32'h0000_0084);

    // return with call swaps the top entry
    step(3'b101, 0, 0, 1, 0, 0);
    chk("retcall_pc", pc_o, RAS_EN ? 32'h0000_0044 : ILL_V);
    step(3'b101, 0, 0, 0, 0, 0);

    // asynchronous reset between edges
    @(negedge clk);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk("async_pc", pc_o, RST_V);
    chk("async_empty", 32'(ras_empty), 32'd1);
    chk("async_xp", xp_o, 32'h0);
    #1 RESET = 1'b0;
    PCSEL = 3'b000; CALL = 1'b0; IRQ = 1'b0; STALL = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    chk("after_async", pc_o, 32'h8000_0004);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program-counter unit for the RISC core's fetch stage. Selects the next PC from increment, branch, jump, exception vectors, or a hardware return-address stack (RAS). Adds fetch-stall hold, supervisor-mode IRQ masking and exception-PC capture. Drives `pc_o` to instruction memory and `PcIncr`/`branchOffset` to the datapath.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC width; MSB is the supervisor bit.
- `RAS_DEPTH`, 4: return-stack entries; power of two, ≥2.
- `RESET_VECTOR`, 0x8000_0000: PC after reset and for PCSEL 110/111.
- `ILLOP_VECTOR`, 0x8000_0004: illegal-op / RAS-underflow target.
- `XADDR_VECTOR`, 0x8000_0008: interrupt/exception target.

Ports:
- `clk`  in  1  global clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `STALL`  in  1  hold PC and RAS this cycle.
- `PCSEL`  in  3  next-PC source select.
- `IRQ`  in  1  level interrupt request.
- `CALL`  in  1  push return address with taken branch/jump.
- `JT`  in  ADDR_WIDTH  register jump target.
- `ShftSextC`  in  ADDR_WIDTH  4*sign-extended literal.
- `pc_o`  out  ADDR_WIDTH  current PC (registered).
- `PcIncr`  out  ADDR_WIDTH  pc_o+4 (combinational).
- `branchOffset`  out  ADDR_WIDTH  PcIncr+ShftSextC (combinational).
- `xp_o`  out  ADDR_WIDTH  exception PC: PcIncr captured on IRQ/illop/exception.
- `ras_empty`  out  1  RAS holds no entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_underflow`  out  1  one-cycle pulse on pop from empty RAS.

## Operation
- Reset: `pc_o`=RESET_VECTOR, `xp_o`=0, RAS count 0 (`ras_empty`=1, `ras_full`=0), `ras_underflow`=0.
- Priority per edge: RESET > STALL > accepted IRQ > PCSEL.
- IRQ accepted only when `pc_o[MSB]`=0; then pc←XADDR_VECTOR, xp←PcIncr, RAS untouched, CALL ignored. When masked, PCSEL applies normally.
- Let S = `pc_o[MSB]`. PCSEL:
  - 000: pc←{S, PcIncr[MSB-1:0]}.
  - 001: pc←{S, branchOffset[MSB-1:0]}.
  - 010: pc←{S & JT[MSB], JT[MSB-1:0]}; jumps can leave supervisor mode, never enter it.
  - 011: pc←ILLOP_VECTOR, xp←PcIncr.
  - 100: pc←XADDR_VECTOR, xp←PcIncr.
  - 101: RET; pop top T, pc←{S & T[MSB], T[MSB-1:0]}. Empty: pc←ILLOP_VECTOR, xp←PcIncr, `ras_underflow` pulses, count stays 0.
  - 110/111: pc←RESET_VECTOR.
- Bits [1:0] of every loaded PC forced to 00.
- Adders are modulo 2^ADDR_WIDTH; carry out of the low bits never alters S.
- CALL honoured only with PCSEL 001 or 010: push PcIncr. Full: overwrite oldest entry (circular wrap), count stays RAS_DEPTH.
- CALL with PCSEL 101: pop then push in one edge; top replaced by PcIncr, count unchanged; pc from popped value. Empty: underflow path, no push.
- CALL with any other PCSEL, or with accepted IRQ: ignored.

## Timing
- Single-cycle: PCSEL/IRQ/CALL sampled at a rising edge, new `pc_o` valid after that edge.
- `PcIncr` and `branchOffset` follow `pc_o` combinationally, same cycle.
- RAS status flags registered, updated on the same edge as the push/pop.
- `ras_underflow` high for exactly the cycle after the offending edge.
- STALL=1: `pc_o`, `xp_o`, RAS all hold; pending IRQ is taken on the first unstalled edge if still asserted and unmasked.
- RESET asserted mid-operation: all state clears immediately, independent of `clk`.

## Configuration
- `PC_RAS_EN` defined: RAS built as specified.
- Undefined: no RAS storage; PCSEL 101 behaves as 011 (ILLOP_VECTOR, xp capture, no underflow pulse); CALL ignored; `ras_empty`=1, `ras_full`=0, `ras_underflow`=0 constant.

## Test plan
- Reset release, PCSEL=000 ×3 -> `pc_o` 0x8000_0000, then 0x8000_0004, 0x8000_0008, 0x8000_000C; PcIncr always pc_o+4.
- From pc=0x0000_0100, PCSEL=010, JT=0x8000_0203 -> pc=0x0000_0200 (supervisor not entered, low bits cleared); from pc=0x8000_0100, same JT -> 0x8000_0200.
- From pc=0x0000_0010, PCSEL=001, CALL=1, ShftSextC=0x40 -> pc=0x0000_0054, RAS top 0x0000_0014; then PCSEL=101 -> pc=0x0000_0014, `ras_empty`=1.
- Five CALLs with RAS_DEPTH=4 (return addrs A1..A5) -> `ras_full`=1; five RETs -> A5,A4,A3,A2, then ILLOP_VECTOR with `ras_underflow` pulse and xp=PcIncr.
- IRQ=1 at pc=0x0000_0020 -> pc=XADDR_VECTOR, xp=0x0000_0024; IRQ held while at 0x8000_0008 -> ignored, PCSEL=000 advances to 0x8000_000C.
- STALL=1 for 3 cycles with PCSEL=001, CALL=1 -> pc and RAS unchanged; RESET pulse between edges -> pc_o=RESET_VECTOR and `ras_empty`=1 before next clock edge.
